// File: rtl/axi_wr_slave_ctrl_pkg.sv
// Shared AXI protocol types and default bus geometry for the write/read controllers.
package axiprotocol;

    localparam int unsigned AXI_WIDTH = 32;
    localparam int unsigned AXI_SIZE  = 3;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_state_t;

endpackage

// File: rtl/axi_wr_slave_ctrl_addr_gen.sv
// Next-beat byte address for FIXED/INCR/WRAP bursts; purely combinational.
module axi_burst_addr_gen
    import axiprotocol::*;
#(
    parameter int unsigned WIDTH = AXI_WIDTH,
    parameter int unsigned SIZE  = AXI_SIZE
) (
    input  logic [WIDTH-1:0]   addr,
    input  logic [SIZE-1:0]    size,
    input  logic [WIDTH/8-1:0] len,
    input  logic [SIZE-2:0]    burst,
    output logic [WIDTH-1:0]   next_addr
);

    logic [WIDTH-1:0] bytes;
    logic [WIDTH-1:0] beats;
    logic [WIDTH-1:0] container;

    // Wrap container base is derived from the current address, which always
    // lies inside the same container as the start address.
    always_comb begin
        bytes     = WIDTH'(1) << size;
        beats     = WIDTH'(len) + WIDTH'(1);
        container = beats * bytes;
        next_addr = addr;
        if (burst == (SIZE-1)'(INCR)) begin
            next_addr = (addr & ~(bytes - WIDTH'(1))) + bytes;
        end else if (burst == (SIZE-1)'(WRAP)) begin
            next_addr = (addr & ~(container - WIDTH'(1)))
                      | ((addr + bytes) & (container - WIDTH'(1)));
        end
    end

endmodule

// File: rtl/axi_wr_slave_ctrl.sv
// AXI write-channel slave: one outstanding burst, AW -> W beats -> B response.
module axi_wr_slave_ctrl
    import axiprotocol::*;
#(
    parameter int unsigned WIDTH = AXI_WIDTH,
    parameter int unsigned SIZE  = AXI_SIZE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [WIDTH/8-1:0] AWID,
    input  logic [WIDTH-1:0]   AWADDR,
    input  logic [WIDTH/8-1:0] AWLEN,
    input  logic [SIZE-1:0]    AWSIZE,
    input  logic [SIZE-2:0]    AWBURST,
    input  logic               WVALID,
    output logic               WREADY,
    input  logic [WIDTH/8-1:0] WID,
    input  logic [WIDTH-1:0]   WDATA,
    input  logic [WIDTH/8-1:0] WSTRB,
    input  logic               WLAST,
    output logic               BVALID,
    input  logic               BREADY,
    output logic [WIDTH/8-1:0] BID,
    output logic [SIZE-2:0]    BRESP,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WIDTH/8-1:0] mem_wstrb
);

    localparam int unsigned LW = WIDTH / 8;
    localparam int unsigned BW = SIZE - 1;

    wr_state_t        state_q;
    logic [LW-1:0]    id_q;
    logic [WIDTH-1:0] addr_q;
    logic [LW-1:0]    len_q;
    logic [SIZE-1:0]  size_q;
    logic [BW-1:0]    burst_q;
    logic [LW-1:0]    cnt_q;
    logic             err_q;

    logic             aw_hs;
    logic             w_hs;
    logic             aw_err;
    logic [WIDTH-1:0] aw_bytes;
    logic [WIDTH-1:0] next_addr;
    logic             at_len;

    axi_burst_addr_gen #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Handshakes, accept-time error screening and channel outputs.
    always_comb begin
        AWREADY   = (state_q == IDLE);
        WREADY    = (state_q == DATA);
        BVALID    = (state_q == RESP);
        aw_hs     = AWVALID && AWREADY;
        w_hs      = WVALID && WREADY;
        at_len    = (cnt_q == len_q);
        aw_bytes  = WIDTH'(1) << AWSIZE;
        aw_err    = (AWBURST == BW'(RSVD))
                 || (aw_bytes > WIDTH'(LW))
                 || ((AWBURST == BW'(WRAP))
                     && !(AWLEN inside {LW'(1), LW'(3), LW'(7), LW'(15)}));
        BID       = id_q;
        BRESP     = (BVALID && err_q) ? BW'(SLVERR) : BW'(OKAY);
        mem_we    = w_hs && !err_q && (WID == id_q);
        mem_addr  = addr_q;
        mem_wdata = WDATA;
        mem_wstrb = WSTRB;
    end

    // Transaction sequencing; reset abandons any burst in flight without a response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        id_q    <= AWID;
                        addr_q  <= AWADDR;
                        len_q   <= AWLEN;
                        size_q  <= AWSIZE;
                        burst_q <= AWBURST;
                        cnt_q   <= '0;
                        err_q   <= aw_err;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        cnt_q  <= cnt_q + LW'(1);
                        addr_q <= next_addr;
                        if (WID != id_q) begin
                            err_q <= 1'b1;
                        end
                        if (at_len || WLAST) begin
                            state_q <= RESP;
                            if (!(at_len && WLAST)) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_slave_ctrl.sv
// Directed bench for axi_wr_slave_ctrl with hand-computed beat addresses and responses.
module tb_axi_wr_slave_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [3:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [3:0]  WID = '0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    int total = 0;
    int bad = 0;
    int we_cnt = 0;

    axi_wr_slave_ctrl #(.WIDTH(32), .SIZE(3)) dut (
        .clk(clk), .reset(reset),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
        .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WID(WID), .WDATA(WDATA),
        .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk);
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        #1;
        chk("awready", AWREADY, 1);
        chk("wready_idle", WREADY, 0);
        @(posedge clk);
        #1;
        AWVALID = 1'b0;
        we_cnt = 0;
    endtask

    task automatic do_beat(input logic [3:0] wid, input logic [31:0] data, input logic last,
                           input logic exp_we, input logic [31:0] exp_addr);
        @(negedge clk);
        WVALID = 1'b1; WID = wid; WDATA = data; WSTRB = 4'hF; WLAST = last;
        #1;
        chk("wready", WREADY, 1);
        chk("awready_data", AWREADY, 0);
        chk("mem_we", mem_we, exp_we);
        if (mem_we) we_cnt++;
        if (exp_we) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, data);
            chk("mem_wstrb", mem_wstrb, 4'hF);
        end
        @(posedge clk);
        #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic do_resp(input logic [3:0] exp_id, input logic [1:0] exp_resp,
                           input int exp_we, input int hold);
        @(negedge clk);
        chk("we_count", we_cnt, exp_we);
        chk("bvalid", BVALID, 1);
        chk("bid", BID, exp_id);
        chk("bresp", BRESP, exp_resp);
        chk("wready_resp", WREADY, 0);
        chk("awready_resp", AWREADY, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bvalid_hold", BVALID, 1);
            chk("bid_hold", BID, exp_id);
            chk("bresp_hold", BRESP, exp_resp);
            chk("awready_hold", AWREADY, 0);
        end
        BREADY = 1'b1;
        @(posedge clk);
        #1;
        BREADY = 1'b0;
        chk("bvalid_clr", BVALID, 0);
        chk("awready_back", AWREADY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 reset = 1'b0;
        #4;
        chk("rst_awready", AWREADY, 1);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_bid", BID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_mem_we", mem_we, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // INCR, four beats
        do_aw(4'd5, 32'h100, 4'd3, 3'd2, 2'b01);
        do_beat(4'd5, 32'hA0, 1'b0, 1'b1, 32'h100);
        do_beat(4'd5, 32'hA1, 1'b0, 1'b1, 32'h104);
        do_beat(4'd5, 32'hA2, 1'b0, 1'b1, 32'h108);
        do_beat(4'd5, 32'hA3, 1'b1, 1'b1, 32'h10C);
        do_resp(4'd5, 2'b00, 4, 0);

        // WRAP, 16-byte container at 0x30
        do_aw(4'd1, 32'h38, 4'd3, 3'd2, 2'b10);
        do_beat(4'd1, 32'hB0, 1'b0, 1'b1, 32'h38);
        do_beat(4'd1, 32'hB1, 1'b0, 1'b1, 32'h3C);
        do_beat(4'd1, 32'hB2, 1'b0, 1'b1, 32'h30);
        do_beat(4'd1, 32'hB3, 1'b1, 1'b1, 32'h34);
        do_resp(4'd1, 2'b00, 4, 0);

        // FIXED, three beats
        do_aw(4'd2, 32'h40, 4'd2, 3'd2, 2'b00);
        do_beat(4'd2, 32'hC0, 1'b0, 1'b1, 32'h40);
        do_beat(4'd2, 32'hC1, 1'b0, 1'b1, 32'h40);
        do_beat(4'd2, 32'hC2, 1'b1, 1'b1, 32'h40);
        do_resp(4'd2, 2'b00, 3, 0);

        // early WLAST on beat 2 of 4
        do_aw(4'd3, 32'h200, 4'd3, 3'd2, 2'b01);
        do_beat(4'd3, 32'hD0, 1'b0, 1'b1, 32'h200);
        do_beat(4'd3, 32'hD1, 1'b1, 1'b1, 32'h204);
        do_resp(4'd3, 2'b10, 2, 0);

        // reserved burst type
        do_aw(4'd4, 32'h0, 4'd1, 3'd2, 2'b11);
        do_beat(4'd4, 32'hE0, 1'b0, 1'b0, 32'h0);
        do_beat(4'd4, 32'hE1, 1'b1, 1'b0, 32'h0);
        do_resp(4'd4, 2'b10, 0, 0);

        // beat size wider than the bus
        do_aw(4'd6, 32'h0, 4'd1, 3'd3, 2'b01);
        do_beat(4'd6, 32'hF0, 1'b0, 1'b0, 32'h0);
        do_beat(4'd6, 32'hF1, 1'b1, 1'b0, 32'h0);
        do_resp(4'd6, 2'b10, 0, 0);

        // WRAP with illegal length (3 beats)
        do_aw(4'd13, 32'h0, 4'd2, 3'd2, 2'b10);
        do_beat(4'd13, 32'h10, 1'b0, 1'b0, 32'h0);
        do_beat(4'd13, 32'h11, 1'b0, 1'b0, 32'h0);
        do_beat(4'd13, 32'h12, 1'b1, 1'b0, 32'h0);
        do_resp(4'd13, 2'b10, 0, 0);

        // WID mismatch on first beat suppresses all writes
        do_aw(4'd7, 32'h300, 4'd1, 3'd2, 2'b01);
        do_beat(4'd8, 32'h20, 1'b0, 1'b0, 32'h300);
        do_beat(4'd7, 32'h21, 1'b1, 1'b0, 32'h304);
        do_resp(4'd7, 2'b10, 0, 0);

        // missing WLAST at final beat
        do_aw(4'd10, 32'h600, 4'd1, 3'd2, 2'b01);
        do_beat(4'd10, 32'h30, 1'b0, 1'b1, 32'h600);
        do_beat(4'd10, 32'h31, 1'b0, 1'b1, 32'h604);
        do_resp(4'd10, 2'b10, 2, 0);

        // back-pressured response
        do_aw(4'd9, 32'h500, 4'd0, 3'd2, 2'b01);
        do_beat(4'd9, 32'h40, 1'b1, 1'b1, 32'h500);
        do_resp(4'd9, 2'b00, 1, 5);

        // reset in the middle of a burst
        do_aw(4'd11, 32'h700, 4'd3, 3'd2, 2'b01);
        do_beat(4'd11, 32'h50, 1'b0, 1'b1, 32'h700);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_awready", AWREADY, 1);
        chk("midrst_wready", WREADY, 0);
        chk("midrst_bvalid", BVALID, 0);
        chk("midrst_bid", BID, 0);
        @(negedge clk);
        reset = 1'b1;
        do_aw(4'd12, 32'h10, 4'd0, 3'd2, 2'b01);
        do_beat(4'd12, 32'h60, 1'b1, 1'b1, 32'h10);
        do_resp(4'd12, 2'b00, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_wr_slave_ctrl.md
Name: axi_wr_slave_ctrl

Overview:
AXI write-path slave controller that sequences the AW, W and B channels for one outstanding write transaction at a time. It accepts a write address burst, walks the data beats while generating per-beat memory write strobes and addresses, then issues the write response. It sits between the AXI interconnect/bus-functional model and a simple byte-strobed memory or register array.

Parameters:
WIDTH, 32, data/address bus width in bits; ID/LEN/STRB width is WIDTH/8
SIZE, 3, AxSIZE width in bits; BURST/RESP width is SIZE-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWID  in  WIDTH/8  transaction ID
AWADDR  in  WIDTH  start byte address
AWLEN  in  WIDTH/8  beats minus one
AWSIZE  in  SIZE  log2 bytes per beat
AWBURST  in  SIZE-1  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WID  in  WIDTH/8  data ID
WDATA  in  WIDTH  write data
WSTRB  in  WIDTH/8  byte lane strobes
WLAST  in  1  last beat marker
BVALID  out  1  response valid
BREADY  in  1  response ready
BID  out  WIDTH/8  response ID
BRESP  out  SIZE-1  00 OKAY, 10 SLVERR
mem_we  out  1  memory write enable
mem_addr  out  WIDTH  beat byte address
mem_wdata  out  WIDTH  pass-through of WDATA
mem_wstrb  out  WIDTH/8  pass-through of WSTRB

Behaviour:
- Reset (reset low, asynchronous): state IDLE; AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=00, mem_we=0, beat counter=0, error flag=0, latched ID/addr/len/size/burst=0. Reset mid-burst aborts the transaction; no response is issued.
- FSM states: IDLE, DATA, RESP.
- IDLE: AWREADY=1. On AWVALID&&AWREADY, latch AWID, AWADDR, AWLEN, AWSIZE, AWBURST; clear beat counter; go to DATA the next cycle. Error flag set at accept if AWBURST=11, 2^AWSIZE > WIDTH/8, or WRAP with AWLEN not in {1,3,7,15}.
- DATA: AWREADY=0, WREADY=1. A beat completes on WVALID&&WREADY. mem_we=WVALID&&WREADY&&!error (combinational, same cycle); mem_addr=current beat address; mem_wdata/mem_wstrb mirror WDATA/WSTRB.
- WID != latched ID on any beat: set error; the beat is accepted but not written. Subsequent beats are not written.
- Beat counter increments per completed beat. Counter==latched LEN with WLAST=1: go to RESP. Counter==LEN with WLAST=0: set SLVERR, go to RESP. WLAST=1 with counter<LEN: set SLVERR, go to RESP (early termination).
- Address generation, bytes=2^size: FIXED keeps the start address; INCR next=(addr & ~(bytes-1))+bytes, wrapping modulo 2^WIDTH; WRAP container=(LEN+1)*bytes aligned down from the start address, next=container_base | ((addr+bytes) & (container-1)).
- RESP: WREADY=0, BVALID=1, BID=latched ID, BRESP=error?10:00, held stable until BREADY. On BVALID&&BREADY go to IDLE; AWREADY is high again the next cycle.
- Minimum latency: AW accept cycle n; first W beat accepted at n+1; BVALID asserted the cycle after the last beat.
- Exactly one transaction outstanding; AW is not accepted in DATA or RESP.

Decomposition:
- Package axiprotocol: burst_t enum (FIXED/INCR/WRAP/RSVD), resp_t enum (OKAY/EXOKAY/SLVERR/DECERR), wr_state_t enum (IDLE/DATA/RESP), constants for the default WIDTH/SIZE.
- Sub-module axi_burst_addr_gen: combinational next-address function from current address, size, len and burst; shared with the future read-channel controller.

Test Plan:
- INCR AWADDR=0x100, LEN=3, SIZE=2, ID=5, four beats with WLAST on beat 4 -> mem_addr 0x100/0x104/0x108/0x10C, four mem_we pulses, BID=5, BRESP=00.
- WRAP AWADDR=0x38, LEN=3, SIZE=2 -> mem_addr 0x38/0x3C/0x30/0x34, BRESP=00.
- FIXED AWADDR=0x40, LEN=2 -> three writes to 0x40, BRESP=00.
- INCR LEN=3 with WLAST on beat 2 -> two writes, response after beat 2 with BRESP=10; next AW accepted afterwards.
- AWBURST=11 or AWSIZE=3 -> all beats accepted, mem_we never asserted, BRESP=10.
- BREADY held low 5 cycles -> BVALID/BID/BRESP stable and AWREADY=0 throughout; reset low mid-DATA -> AWREADY=1, WREADY=0, BVALID=0 immediately.
